// File: rtl/iq_pkg.sv
// Shared constants and entry layout for the 16-entry issue queue.
package iq_pkg;
  localparam int IQ_DEPTH     = 16;
  localparam int IQ_IDX_W     = 4;
  localparam int IQ_CNT_W     = 5;
  localparam int IQ_TAG_W     = 6;
  localparam int IQ_PAYLOAD_W = 32;

  typedef struct packed {
    logic valid;
    logic src1_rdy;
    logic src2_rdy;
  } iq_ctl_t;

  // Full entry record at default widths; the top keeps the same fields as separate parameterized arrays.
  typedef struct packed {
    iq_ctl_t                 ctl;
    logic [IQ_TAG_W-1:0]     src1_tag;
    logic [IQ_TAG_W-1:0]     src2_tag;
    logic [IQ_TAG_W-1:0]     dst_tag;
    logic [IQ_PAYLOAD_W-1:0] payload;
  } iq_entry_t;
endpackage

// File: rtl/iq_free_finder.sv
// Lowest-index set bit of a free mask; found=0 when no slot is free.
module iq_free_finder
  import iq_pkg::*;
(
  input  logic [IQ_DEPTH-1:0] free,
  output logic [IQ_IDX_W-1:0] idx,
  output logic                found
);
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = IQ_DEPTH-1; i >= 0; i--) begin
      if (free[i]) begin
        idx   = IQ_IDX_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/issue_queue.sv
// 16-entry out-of-order issue queue with tag wakeup and an external arbiter.
// Optional macro IQ_WAKE_BYPASS_EN lets a same-cycle wake complete readiness.
module issue_queue
  import iq_pkg::*;
#(
  parameter int TAG_W     = IQ_TAG_W,
  parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [TAG_W-1:0]     alloc_src1_tag,
  input  logic [TAG_W-1:0]     alloc_src2_tag,
  input  logic [TAG_W-1:0]     alloc_dst_tag,
  input  logic                 alloc_src1_rdy,
  input  logic                 alloc_src2_rdy,
  input  logic [PAYLOAD_W-1:0] alloc_payload,
  input  logic                 wake_valid,
  input  logic [TAG_W-1:0]     wake_tag,
  output logic [IQ_DEPTH-1:0]  ready,
  input  logic [IQ_DEPTH-1:0]  grant,
  input  logic                 issue_stall,
  input  logic                 flush,
  output logic                 issue_valid,
  output logic [TAG_W-1:0]     issue_dst_tag,
  output logic [PAYLOAD_W-1:0] issue_payload,
  output logic [IQ_IDX_W-1:0]  issue_idx,
  output logic [IQ_CNT_W-1:0]  count
);
  iq_ctl_t [IQ_DEPTH-1:0]                 ctl;
  logic    [IQ_DEPTH-1:0][TAG_W-1:0]     s1_tag, s2_tag, dst_tag;
  logic    [IQ_DEPTH-1:0][PAYLOAD_W-1:0] payload;
  logic    [IQ_DEPTH-1:0]                vld, wk1, wk2, gnt_ok;
  logic    [IQ_IDX_W-1:0]                free_idx, gnt_idx;
  logic                                  free_found, alloc_fire, issue_fire;
  logic                                  alloc_s1, alloc_s2;
  logic    [IQ_CNT_W-1:0]                cnt;

  for (genvar i = 0; i < IQ_DEPTH; i++) begin : g_ent
    assign vld[i] = ctl[i].valid;
    assign wk1[i] = wake_valid && (s1_tag[i] == wake_tag);
    assign wk2[i] = wake_valid && (s2_tag[i] == wake_tag);
`ifdef IQ_WAKE_BYPASS_EN
    assign ready[i] = ctl[i].valid & ~issue_stall
                    & (ctl[i].src1_rdy | wk1[i]) & (ctl[i].src2_rdy | wk2[i]);
`else
    assign ready[i] = ctl[i].valid & ~issue_stall & ctl[i].src1_rdy & ctl[i].src2_rdy;
`endif
  end

  // Free slots come from registered valid bits, so an issuing slot is not reused this cycle.
  iq_free_finder u_free (.free(~vld), .idx(free_idx), .found(free_found));

  assign count       = cnt;
  assign alloc_ready = (cnt != IQ_CNT_W'(IQ_DEPTH));
  assign alloc_fire  = alloc_valid & alloc_ready & free_found & ~flush;
  assign alloc_s1    = alloc_src1_rdy | (wake_valid && (alloc_src1_tag == wake_tag));
  assign alloc_s2    = alloc_src2_rdy | (wake_valid && (alloc_src2_tag == wake_tag));
  assign gnt_ok      = grant & ready;
  assign issue_fire  = |gnt_ok;

  always_comb begin
    gnt_idx = '0;
    for (int i = IQ_DEPTH-1; i >= 0; i--)
      if (gnt_ok[i]) gnt_idx = IQ_IDX_W'(i);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)   ctl <= '0;
    else if (flush) ctl <= '0;
    else begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        if (wk1[i])    ctl[i].src1_rdy <= 1'b1;
        if (wk2[i])    ctl[i].src2_rdy <= 1'b1;
        if (gnt_ok[i]) ctl[i].valid    <= 1'b0;
        if (alloc_fire && free_idx == IQ_IDX_W'(i))
          ctl[i] <= '{valid: 1'b1, src1_rdy: alloc_s1, src2_rdy: alloc_s2};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (alloc_fire) begin
      s1_tag[free_idx]  <= alloc_src1_tag;
      s2_tag[free_idx]  <= alloc_src2_tag;
      dst_tag[free_idx] <= alloc_dst_tag;
      payload[free_idx] <= alloc_payload;
    end
    if (issue_fire) begin
      issue_dst_tag <= dst_tag[gnt_idx];
      issue_payload <= payload[gnt_idx];
      issue_idx     <= gnt_idx;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      issue_valid <= 1'b0;
      cnt         <= '0;
    end else if (flush) begin
      issue_valid <= 1'b0;
      cnt         <= '0;
    end else begin
      issue_valid <= issue_fire;
      cnt         <= cnt + IQ_CNT_W'(alloc_fire) - IQ_CNT_W'(issue_fire);
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Randomized scoreboard bench for issue_queue against an entry-array reference model.
module tb_issue_queue;
  localparam int TW = 6;
  localparam int PW = 32;
`ifdef IQ_WAKE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK = 1'b0, RESET_N = 1'b0;
  logic alloc_valid = 0, alloc_ready, alloc_src1_rdy = 0, alloc_src2_rdy = 0;
  logic [TW-1:0] alloc_src1_tag = '0, alloc_src2_tag = '0, alloc_dst_tag = '0, wake_tag = '0;
  logic [PW-1:0] alloc_payload = '0;
  logic wake_valid = 0, issue_stall = 0, flush = 0, issue_valid;
  logic [15:0] ready, grant = '0;
  logic [TW-1:0] issue_dst_tag;
  logic [PW-1:0] issue_payload;
  logic [3:0] issue_idx;
  logic [4:0] count;

  always #5 CLK = ~CLK;

  issue_queue #(.TAG_W(TW), .PAYLOAD_W(PW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_src1_tag(alloc_src1_tag), .alloc_src2_tag(alloc_src2_tag), .alloc_dst_tag(alloc_dst_tag),
    .alloc_src1_rdy(alloc_src1_rdy), .alloc_src2_rdy(alloc_src2_rdy), .alloc_payload(alloc_payload),
    .wake_valid(wake_valid), .wake_tag(wake_tag), .ready(ready), .grant(grant),
    .issue_stall(issue_stall), .flush(flush), .issue_valid(issue_valid),
    .issue_dst_tag(issue_dst_tag), .issue_payload(issue_payload), .issue_idx(issue_idx), .count(count));

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model: one record per slot, updated once per cycle from the driven inputs.
  bit          mv[16], m1[16], m2[16];
  logic [TW-1:0] mt1[16], mt2[16], mtd[16];
  logic [PW-1:0] mpl[16];
  typedef struct { logic [3:0] idx; logic [TW-1:0] dst; logic [PW-1:0] pl; int cyc; } pkt_t;
  pkt_t sb[$];
  logic [15:0] obs_ready;
  logic [4:0]  obs_count;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 16; i++) if (mv[i]) n++;
    return n;
  endfunction

  function automatic logic [15:0] m_ready(input bit wv, input logic [TW-1:0] wt, input bit st);
    logic [15:0] r = '0;
    for (int i = 0; i < 16; i++)
      r[i] = mv[i] && !st && (m1[i] || (BYP && wv && mt1[i] == wt))
                          && (m2[i] || (BYP && wv && mt2[i] == wt));
    return r;
  endfunction

  // gsel: -1 no grant, 0..15 that bit, 16 a random model-ready entry
  task automatic step(input bit av, input logic [TW-1:0] t1, t2, td, input bit r1, r2,
                      input logic [PW-1:0] pl, input bit wv, input logic [TW-1:0] wt,
                      input bit st, fl, input int gsel);
    logic [15:0] mr;
    int g, k, slot;
    pkt_t p;
    @(negedge CLK);
    alloc_valid = av; alloc_src1_tag = t1; alloc_src2_tag = t2; alloc_dst_tag = td;
    alloc_src1_rdy = r1; alloc_src2_rdy = r2; alloc_payload = pl;
    wake_valid = wv; wake_tag = wt; issue_stall = st; flush = fl;
    mr = m_ready(wv, wt, st);
    g = -1;
    if (gsel >= 0 && gsel < 16) g = gsel;
    else if (gsel == 16 && mr != 0) begin
      k = $urandom_range($countones(mr) - 1);
      for (int i = 0; i < 16; i++) if (mr[i]) begin if (k == 0) g = i; k--; end
    end
    grant = '0;
    if (g >= 0) grant[g] = 1'b1;
    #1;
    obs_ready = ready; obs_count = count;
    chk("ready", ready, mr);
    chk("count", count, m_count());
    chk("alloc_ready", alloc_ready, m_count() != 16);
    if (fl) begin
      for (int i = 0; i < 16; i++) mv[i] = 0;
    end else begin
      slot = -1;
      if (av && m_count() < 16)
        for (int i = 15; i >= 0; i--) if (!mv[i]) slot = i;
      if (g >= 0 && mr[g]) begin
        p.idx = 4'(g); p.dst = mtd[g]; p.pl = mpl[g]; p.cyc = cyc + 1;
        sb.push_back(p);
        mv[g] = 0;
      end
      if (wv)
        for (int i = 0; i < 16; i++) if (mv[i]) begin
          if (mt1[i] == wt) m1[i] = 1;
          if (mt2[i] == wt) m2[i] = 1;
        end
      if (slot >= 0) begin
        mv[slot] = 1; mt1[slot] = t1; mt2[slot] = t2; mtd[slot] = td; mpl[slot] = pl;
        m1[slot] = r1 || (wv && t1 == wt);
        m2[slot] = r2 || (wv && t2 == wt);
      end
    end
  endtask

  task automatic idle(input int gsel, input bit st);
    step(0, '0, '0, '0, 0, 0, '0, 0, '0, st, 0, gsel);
  endtask

  task automatic alloc1(input logic [TW-1:0] t1, t2, input bit r1, r2, input int gsel);
    step(1, t1, t2, TW'($urandom), r1, r2, $urandom, 0, '0, 0, 0, gsel);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 0; alloc_valid = 0; grant = '0; flush = 0; wake_valid = 0; issue_stall = 0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_ready", ready, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_issue_valid", issue_valid, 0);
    for (int i = 0; i < 16; i++) mv[i] = 0;
    sb.delete();
    @(negedge CLK);
    RESET_N = 1;
  endtask

  // Monitor: every presented issue packet must match the oldest expected one, in its cycle.
  always @(posedge CLK) begin
    #1;
    if (RESET_N) begin
      if (issue_valid) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL issue_unexpected: got idx %0d expected no issue", issue_idx);
        end else begin
          pkt_t p;
          p = sb.pop_front();
          chk("issue_idx", issue_idx, p.idx);
          chk("issue_dst", issue_dst_tag, p.dst);
          chk("issue_payload", issue_payload, p.pl);
          chk("issue_cycle", cyc, p.cyc);
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        checks++; failures++;
        $display("FAIL issue_missing: got issue_valid 0 expected idx %0d", sb[0].idx);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    do_reset();
    // operand wakeup timing
    alloc1(5, 6, 0, 0, -1);
    step(0, '0, '0, '0, 0, 0, '0, 1, 6'd5, 0, 0, -1);
    step(0, '0, '0, '0, 0, 0, '0, 1, 6'd6, 0, 0, -1);
    chk("wake6_same_cycle", obs_ready[0], BYP);
    idle(16, 0);
    chk("wake6_next_cycle", obs_ready[0], 1);
    idle(-1, 0);
    // wake coincident with allocation
    do_reset();
    step(1, 6'd9, 6'd3, 6'd1, 0, 1, 32'hA5A5_0009, 1, 6'd9, 0, 0, -1);
    idle(-1, 0);
    chk("alloc_wake_src1", obs_ready[0], 1);
    idle(0, 0);
    // full queue, issue frees slot 3, refill lands there
    do_reset();
    repeat (16) alloc1(TW'($urandom), TW'($urandom), 1, 1, -1);
    idle(-1, 0);
    chk("full_count", obs_count, 16);
    chk("full_alloc_ready", alloc_ready, 0);
    alloc1(1, 2, 1, 1, 3);
    idle(-1, 0);
    chk("after_grant3_count", obs_count, 15);
    chk("slot3_free", obs_ready[3], 0);
    alloc1(1, 2, 1, 1, -1);
    idle(-1, 0);
    chk("refill_ready", obs_ready, 16'hFFFF);
    idle(3, 0);
    alloc1(1, 2, 1, 1, 5);
    idle(-1, 0);
    chk("alloc_issue_same_cycle", obs_count, 15);
    // stall suppresses ready; then entry 7 issues
    do_reset();
    repeat (8) alloc1(TW'($urandom), TW'($urandom), 1, 1, -1);
    idle(7, 1);
    chk("stall_ready", obs_ready, 0);
    @(posedge CLK); #2;
    chk("stall_no_issue", issue_valid, 0);
    idle(7, 0);
    @(posedge CLK); #2;
    chk("grant7_valid", issue_valid, 1);
    chk("grant7_idx", issue_idx, 7);
    // flush dominates alloc and grant
    step(1, 1, 2, 3, 1, 1, 32'h1234, 0, '0, 0, 1, 16);
    @(posedge CLK); #2;
    chk("flush_issue_valid", issue_valid, 0);
    idle(-1, 0);
    chk("flush_count", obs_count, 0);
    chk("flush_ready", obs_ready, 0);
    // asynchronous reset with 10 entries in flight
    repeat (10) alloc1(TW'($urandom), TW'($urandom), 1'($urandom), 1, -1);
    idle(-1, 0);
    chk("ten_count", obs_count, 10);
    do_reset();
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r, gs;
      r = $urandom_range(7);
      gs = (r == 0) ? -1 : (r == 1) ? int'($urandom_range(15)) : 16;
      step(($urandom % 4) != 0, TW'($urandom_range(7)), TW'($urandom_range(7)), TW'($urandom),
           ($urandom % 3) == 0, ($urandom % 3) == 0, $urandom,
           $urandom % 2, TW'($urandom_range(7)), ($urandom % 6) == 0, ($urandom % 50) == 0, gs);
    end
    repeat (3) idle(-1, 0);
    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter TAG_W, default 6, physical register tag width.
REQ-002 SHALL have parameter PAYLOAD_W, default 32, opaque instruction payload width.
REQ-003 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports alloc_valid/alloc_ready  in/out  1/1  dispatch handshake.
REQ-006 SHALL have ports alloc_src1_tag, alloc_src2_tag, alloc_dst_tag  input  TAG_W each  operand/destination tags.
REQ-007 SHALL have ports alloc_src1_rdy, alloc_src2_rdy  input  1 each  operand already available.
REQ-008 SHALL have port alloc_payload  input  PAYLOAD_W  instruction payload.
REQ-009 SHALL have ports wake_valid/wake_tag  input  1/TAG_W  result broadcast bus.
REQ-010 SHALL have port ready  output  16  per-entry request vector to the 16-way arbiter.
REQ-011 SHALL have port grant  input  16  one-hot grant from arbiter, combinational from ready.
REQ-012 SHALL have port issue_stall  input  1  functional unit cannot accept.
REQ-013 SHALL have port flush  input  1  discard all entries.
REQ-014 SHALL have ports issue_valid, issue_dst_tag, issue_payload, issue_idx  output  1/TAG_W/PAYLOAD_W/4  registered issue packet.
REQ-015 SHALL have port count  output  5  occupied entries, 0..16.

Function
REQ-016 Each of 16 entries SHALL hold valid, src1_rdy, src2_rdy, src tags, dst_tag, payload.
REQ-017 ready[i] SHALL equal valid[i] & src1_rdy[i] & src2_rdy[i] & ~issue_stall.
REQ-018 alloc_ready SHALL be (count != 16), from registered state only; no same-cycle reuse of a slot being issued.
REQ-019 Accepted alloc SHALL write the lowest-index free entry at the edge; full queue leaves alloc_valid unaccepted.
REQ-020 Wake with wake_valid SHALL set every matching valid entry's srcN_rdy at the edge.
REQ-021 Wake matching an allocating source tag in the same cycle SHALL store that source as ready.
REQ-022 Grant bit i with ready[i]=1 SHALL clear valid[i] and load issue registers at the edge; issue_valid high exactly the next cycle (latency 1).
REQ-023 Grant bits for non-ready entries, or all-zero grant, SHALL be ignored; issue_valid 0 next cycle.
REQ-024 Alloc and issue in the same cycle SHALL both occur; count unchanged.
REQ-025 flush SHALL clear all valid bits and issue_valid at the edge; dominates same-cycle alloc and grant.
REQ-026 count SHALL track popcount of valid bits, never wrap past 16 or below 0.

Reset
REQ-027 RESET_N low SHALL immediately clear all valid bits, issue_valid, count to 0; alloc_ready reads 1.
REQ-028 Reset asserted mid-operation SHALL drop all in-flight entries and the pending issue packet; payload/tag registers need not reset.

Configuration
REQ-029 Macro IQ_WAKE_BYPASS_EN defined: ready[i] SHALL also assert when the only missing operand matches wake_tag with wake_valid the same cycle (speculative issue).
REQ-030 Macro undefined: ready SHALL depend on registered operand state only; woken entry becomes ready one cycle after wake.

Structure
REQ-031 Package iq_pkg SHALL hold IQ_DEPTH=16, IQ_IDX_W=4, default TAG_W/PAYLOAD_W, and the entry record layout.
REQ-032 Lowest-free-slot selection SHALL be sub-module iq_free_finder (16-bit free mask -> 4-bit index + found).

Verification
REQ-033 Reset, alloc src tags 5/6 not ready, wake 5 then 6 -> ready[0] rises cycle after wake 6 (bypass off), one cycle earlier with bypass on.
REQ-034 Fill 16 allocs with ready operands -> count=16, alloc_ready=0; grant entry 3 -> count 15, next alloc lands in entry 3.
REQ-035 Entry 7 ready, grant=0x0080, issue_stall=0 -> issue_valid=1, issue_idx=7 next cycle; with issue_stall=1, ready=0x0000, no issue.
REQ-036 Alloc with src1_tag=9 while wake_tag=9 -> entry stored src1_rdy=1.
REQ-037 Flush with alloc_valid and grant active -> count=0, issue_valid=0, entry not written.
REQ-038 RESET_N low mid-stream with 10 entries -> count=0, ready=0 immediately, before next CLK edge.
